// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU op encoding and RV32I opcode/funct constants, used by the issue stage and the ALU.
package alu_issue_stage_pkg;

  typedef enum logic [3:0] {
    AluAdd     = 4'b0000,
    AluSub     = 4'b0001,
    AluSll     = 4'b0010,
    AluSlt     = 4'b0011,
    AluSltu    = 4'b0100,
    AluXor     = 4'b0101,
    AluSrl     = 4'b0110,
    AluSra     = 4'b0111,
    AluOr      = 4'b1000,
    AluAnd     = 4'b1001,
    AluIllegal = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OpcodeOp    = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm = 7'b0010011;

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  function automatic logic is_shift(alu_op_e op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

  // Base (funct7 = 0) mapping shared by R-type and I-type.
  function automatic alu_op_e funct3_op(logic [2:0] f3);
    alu_op_e op;
    unique case (f3)
      F3AddSub: op = AluAdd;
      F3Sll:    op = AluSll;
      F3Slt:    op = AluSlt;
      F3Sltu:   op = AluSltu;
      F3Xor:    op = AluXor;
      F3Sr:     op = AluSrl;
      F3Or:     op = AluOr;
      F3And:    op = AluAnd;
      default:  op = AluIllegal;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-instruction decoder: op code, immediate select and illegal flag.
module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  op_o,
  output logic        imm_sel_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    base_op;
  alu_op_e    op;
  logic       unused_fields;

  assign opcode        = instr_i[6:0];
  assign funct3        = instr_i[14:12];
  assign funct7        = instr_i[31:25];
  assign base_op       = funct3_op(funct3);
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    op        = AluIllegal;
    imm_sel_o = 1'b0;
    illegal_o = 1'b1;
    case (opcode)
      OpcodeOp: begin
        if (funct7 == Funct7Base) begin
          op        = base_op;
          illegal_o = 1'b0;
        end else if (funct7 == Funct7Alt && funct3 == F3AddSub) begin
          op        = AluSub;
          illegal_o = 1'b0;
        end else if (funct7 == Funct7Alt && funct3 == F3Sr) begin
          op        = AluSra;
          illegal_o = 1'b0;
        end
      end
      OpcodeOpImm: begin
        // Only the shift-immediates constrain instr[31:25]; the rest is immediate.
        if (funct3 == F3Sll) begin
          if (funct7 == Funct7Base) begin
            op        = AluSll;
            illegal_o = 1'b0;
          end
        end else if (funct3 == F3Sr) begin
          if (funct7 == Funct7Base) begin
            op        = AluSrl;
            illegal_o = 1'b0;
          end else if (funct7 == Funct7Alt) begin
            op        = AluSra;
            illegal_o = 1'b0;
          end
        end else begin
          op        = base_op;
          illegal_o = 1'b0;
        end
        imm_sel_o = !illegal_o;
      end
      default: ;
    endcase
  end

  assign op_o = op;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, register-file read with scoreboard stall and writeback bypass,
// and a single issue register toward the ALU.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [31:0] out_r1,
  output logic [31:0] out_r2,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0] regs_q [32];
  logic [31:0] busy_q, busy_d;

  logic        valid_q;
  logic [3:0]  op_q;
  logic [31:0] r1_q, r2_q;
  logic [4:0]  rd_q;
  logic        illegal_q;

  logic [3:0]  dec_op;
  logic        dec_imm_sel;
  logic        dec_illegal;

  logic [4:0]  rs1, rs2, in_rd;
  logic [31:0] imm, rs1_val, rs2_val, src2;
  logic [31:0] r1_d, r2_d;
  logic [4:0]  rd_d;
  logic        rs1_busy, rs2_busy, hazard, accept;

  alu_op_decode u_decode (
    .instr_i   (in_instr),
    .op_o      (dec_op),
    .imm_sel_o (dec_imm_sel),
    .illegal_o (dec_illegal)
  );

  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign in_rd = in_instr[11:7];
  assign imm   = {{20{in_instr[31]}}, in_instr[31:20]};

  function automatic logic [31:0] read_reg(logic [4:0] a);
    if (a == 5'd0) begin
      return 32'd0;
    end else if (BYPASS_EN && wb_en && wb_rd == a) begin
      return wb_data;
    end
    return regs_q[a];
  endfunction

  function automatic logic still_busy(logic [4:0] a);
    return busy_q[a] && !(BYPASS_EN && wb_en && wb_rd == a);
  endfunction

  always_comb begin
    rs1_val  = read_reg(rs1);
    rs2_val  = read_reg(rs2);
    src2     = dec_imm_sel ? imm : rs2_val;
    rs1_busy = still_busy(rs1);
    rs2_busy = !dec_imm_sel && still_busy(rs2);
    // Illegal instructions never stall and never leave any operand state behind.
    hazard   = !dec_illegal && (rs1_busy || rs2_busy);
    r1_d     = dec_illegal ? 32'd0 : rs1_val;
    r2_d     = dec_illegal ? 32'd0 :
               is_shift(alu_op_e'(dec_op)) ? {27'd0, src2[4:0]} : src2;
    rd_d     = dec_illegal ? 5'd0 : in_rd;
  end

  assign in_ready = !rst && (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // A same-cycle set wins over a writeback clear of the same bit.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && wb_rd != 5'd0) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (accept && !dec_illegal && in_rd != 5'd0) begin
      busy_d[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_q      <= 4'd0;
      r1_q      <= 32'd0;
      r2_q      <= 32'd0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      busy_q    <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      if (accept) begin
        valid_q   <= 1'b1;
        op_q      <= dec_op;
        r1_q      <= r1_d;
        r2_q      <= r2_d;
        rd_q      <= rd_d;
        illegal_q <= dec_illegal;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (wb_en && wb_rd != 5'd0) begin
        regs_q[wb_rd] <= wb_data;
      end
      busy_q <= busy_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op      = op_q;
  assign out_r1      = r1_q;
  assign out_r2      = r2_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic against a reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal, wb_en;
  logic [31:0] in_instr, out_r1, out_r2, wb_data;
  logic [3:0]  out_op;
  logic [4:0]  out_rd, wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_valid, m_ill;
  logic [3:0]  m_op;
  logic [31:0] m_r1, m_r2;
  logic [4:0]  m_rd;

  always #5 clk = ~clk;

  alu_issue_stage #(.BYPASS_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_r1      (out_r1),
    .out_r2      (out_r2),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Decode straight from the instruction-set tables; op 15 means illegal.
  function automatic void ref_decode(input logic [31:0] w, output int op, output bit is_i);
    int         f3map [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    f3map = '{0, 2, 3, 4, 5, 6, 8, 9};
    opc   = w[6:0];
    f3    = w[14:12];
    f7    = w[31:25];
    op    = 15;
    is_i  = 1'b0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) op = f3map[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
    end else if (opc == 7'h13) begin
      is_i = 1'b1;
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) op = 2;
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00) op = 6;
        else if (f7 == 7'h20) op = 7;
      end else begin
        op = f3map[f3];
      end
    end
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] rs, input bit we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (rs == 5'd0) return 32'd0;
    if (we && wrd == rs) return wd;
    return m_regs[rs];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_valid = 1'b0; m_ill = 1'b0; m_op = 4'd0; m_r1 = 32'd0; m_r2 = 32'd0; m_rd = 5'd0;
  endfunction

  // One clock: drive inputs, check in_ready, advance the model, check the issue register.
  task automatic cycle(input bit r, input bit v, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                       output bit rdy_seen);
    int          op;
    bit          is_i, haz, exp_ready, acc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] src2;
    rst = r; in_valid = v; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    ref_decode(ins, op, is_i);
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    haz = (op != 15) && ((m_busy[rs1] && !(we && wrd == rs1)) ||
                         (!is_i && m_busy[rs2] && !(we && wrd == rs2)));
    exp_ready = !r && (!m_valid || ordy) && !haz;
    acc = v && exp_ready;
    #1;
    rdy_seen = in_ready;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (r) begin
      model_reset();
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        if (op == 15) begin
          m_op = 4'hF; m_r1 = 32'd0; m_r2 = 32'd0; m_rd = 5'd0; m_ill = 1'b1;
        end else begin
          m_op = 4'(op);
          m_r1 = ref_read(rs1, we, wrd, wd);
          src2 = is_i ? {{20{ins[31]}}, ins[31:20]} : ref_read(rs2, we, wrd, wd);
          if (op == 2 || op == 6 || op == 7) src2 = src2 % 32;
          m_r2 = src2; m_rd = rd; m_ill = 1'b0;
        end
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (we && wrd != 5'd0) begin
        m_regs[wrd] = wd;
        m_busy[wrd] = 1'b0;
      end
      if (acc && op != 15 && rd != 5'd0) m_busy[rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("out_op", {28'd0, out_op}, {28'd0, m_op});
    check_eq("out_r1", out_r1, m_r1);
    check_eq("out_r2", out_r2, m_r2);
    check_eq("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
    check_eq("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  f7, opc;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    int          sel, k;
    sel = $urandom_range(0, 9);
    f3  = 3'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    k   = $urandom_range(0, 4);
    f7  = (k < 2) ? 7'h00 : (k < 4) ? 7'h20 : 7'($urandom);
    if (sel <= 3) opc = 7'h33;
    else if (sel <= 7) begin
      opc = 7'h13;
      if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom);
    end else if (sel == 8) opc = 7'h7F;
    else return $urandom;
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  initial begin
    bit rdy;
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    @(posedge clk);
    #1;
    cycle(1, 0, 32'd0, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("rst_in_ready", {31'd0, rdy}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cycle(1, 0, 32'd0, 1, 0, 5'd0, 32'd0, rdy);

    // add x3,x1,x2 with x1=5, x2=7
    cycle(0, 0, 32'd0, 1, 1, 5'd1, 32'd5, rdy);
    cycle(0, 0, 32'd0, 1, 1, 5'd2, 32'd7, rdy);
    cycle(0, 1, 32'h002081B3, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("add_accept", {31'd0, rdy}, 32'd1);
    check_eq("add_op", {28'd0, out_op}, 32'd0);
    check_eq("add_r1", out_r1, 32'd5);
    check_eq("add_r2", out_r2, 32'd7);
    check_eq("add_rd", {27'd0, out_rd}, 32'd3);

    // add x4,x3,x0 stalls on busy x3 until x3 is written back with 9
    cycle(0, 1, 32'h00018233, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("raw_stall0", {31'd0, rdy}, 32'd0);
    cycle(0, 1, 32'h00018233, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("raw_stall1", {31'd0, rdy}, 32'd0);
    cycle(0, 1, 32'h00018233, 1, 1, 5'd3, 32'd9, rdy);
    check_eq("raw_bypass_accept", {31'd0, rdy}, 32'd1);
    check_eq("raw_bypass_r1", out_r1, 32'd9);
    check_eq("raw_bypass_rd", {27'd0, out_rd}, 32'd4);

    // addi x1,x0,-1
    cycle(0, 1, 32'hFFF00093, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("addi_op", {28'd0, out_op}, 32'd0);
    check_eq("addi_r1", out_r1, 32'd0);
    check_eq("addi_r2", out_r2, 32'hFFFFFFFF);
    check_eq("addi_rd", {27'd0, out_rd}, 32'd1);

    // srai x5,x1,4 with x1=0x80000000
    cycle(0, 0, 32'd0, 1, 1, 5'd1, 32'h80000000, rdy);
    cycle(0, 1, 32'h4040D293, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("srai_op", {28'd0, out_op}, 32'd7);
    check_eq("srai_r1", out_r1, 32'h80000000);
    check_eq("srai_r2", out_r2, 32'd4);

    // Backpressure: addi x6,x0,5 held while addi x7,x0,3 waits
    cycle(0, 0, 32'd0, 1, 0, 5'd0, 32'd0, rdy);
    cycle(0, 1, 32'h00500313, 0, 0, 5'd0, 32'd0, rdy);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 32'h00300393, 0, 0, 5'd0, 32'd0, rdy);
      check_eq("bp_blocked", {31'd0, rdy}, 32'd0);
      check_eq("bp_hold_r2", out_r2, 32'd5);
      check_eq("bp_hold_rd", {27'd0, out_rd}, 32'd6);
    end
    cycle(0, 1, 32'h00300393, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("bp_release", {31'd0, rdy}, 32'd1);
    check_eq("bp_second_r2", out_r2, 32'd3);

    // Illegal opcode with rd field 8: no scoreboard effect, then reset with out_valid=1
    cycle(0, 1, 32'h0000047F, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("ill_flag", {31'd0, out_illegal}, 32'd1);
    check_eq("ill_op", {28'd0, out_op}, 32'hF);
    check_eq("ill_rd", {27'd0, out_rd}, 32'd0);
    cycle(0, 1, 32'h000404B3, 1, 0, 5'd0, 32'd0, rdy);
    check_eq("ill_no_busy", {31'd0, rdy}, 32'd1);
    cycle(1, 0, 32'd0, 0, 0, 5'd0, 32'd0, rdy);
    check_eq("rst_drop_valid", {31'd0, out_valid}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r, v, ordy, we;
      logic [4:0]  wrd;
      r    = ($urandom_range(0, 99) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 1) == 1);
      wrd  = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      cycle(r, v, rand_instr(), ordy, we, wrd, $urandom, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
